// File: rtl/data_ram_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: state encoding, port IDs and
// the saturating increment used by the fetch starvation counter.
package data_ram_arbiter_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_MEM   = 1'b1;

    typedef enum logic [1:0] {
        stIdle  = IDLE,
        stIssue = ISSUE,
        stDone  = DONE
    } arbState;

    function automatic logic [3:0] satInc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the single-ported data RAM.
// The arbiter uses the slave view; requesters and the RAM together form the master view.
interface data_ram_arbiter_if #(
    parameter int width  = 16,
    parameter int length = 8
);
    logic              fetchReq;
    logic [length-1:0] fetchAddr;
    logic              fetchGnt;
    logic              fetchDone;
    logic [width-1:0]  fetchData;

    logic              memReq;
    logic              memWe;
    logic [length-1:0] memAddr;
    logic [width-1:0]  memWData;
    logic              memGnt;
    logic              memDone;
    logic [width-1:0]  memData;

    logic              ramWe;
    logic              ramRe;
    logic [length-1:0] ramAddr;
    logic [length-1:0] ramReadAddr;
    logic [width-1:0]  ramWData;
    logic              ramReady;
    logic [width-1:0]  ramRData;

    logic              busy;

    modport slave (
        input  fetchReq, fetchAddr,
        input  memReq, memWe, memAddr, memWData,
        input  ramReady, ramRData,
        output fetchGnt, fetchDone, fetchData,
        output memGnt, memDone, memData,
        output ramWe, ramRe, ramAddr, ramReadAddr, ramWData,
        output busy
    );

    modport master (
        output fetchReq, fetchAddr,
        output memReq, memWe, memAddr, memWData,
        output ramReady, ramRData,
        input  fetchGnt, fetchDone, fetchData,
        input  memGnt, memDone, memData,
        input  ramWe, ramRe, ramAddr, ramReadAddr, ramWData,
        input  busy
    );

endinterface

// File: rtl/data_ram_arbiter_fetch_starve_counter.sv
// Counts IDLE cycles in which a pending fetch was refused; once it reaches the
// limit, starve flips arbitration in favour of the fetch port.
module fetch_starve_counter
    import data_ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic       cntClr,
    input  logic [3:0] limit,
    output logic       starve,
    output logic [3:0] waitCnt
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            waitCnt <= 4'd0;
        end else if (cntClr) begin
            waitCnt <= 4'd0;
        end else if (inc) begin
            waitCnt <= satInc(waitCnt, limit);
        end
    end

    assign starve = (waitCnt == limit);

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-ported data RAM between instruction fetch (read-only) and
// load/store (read/write); load/store has priority, bounded by the starvation counter.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   stIdle  | no access in flight; grants are combinational from the requests
//   stIssue | RAM strobe asserted from captured registers; reads wait ramReady
//   stDone  | one-cycle done pulse on the granted port, data register valid
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int width   = 16,
    parameter int length  = 8,
    parameter int maxWait = 3
) (
    input  logic               clk,
    input  logic               clr,
    data_ram_arbiter_if.slave  bus
);

    localparam logic [3:0] waitLimit = 4'(maxWait);

    arbState           state;
    arbState           nextState;

    logic              capPort;
    logic              capWe;
    logic [length-1:0] capAddr;
    logic [width-1:0]  capWData;

    logic              ramWeQ;
    logic              ramReQ;
    logic              fetchDoneQ;
    logic              memDoneQ;
    logic [width-1:0]  fetchDataQ;
    logic [width-1:0]  memDataQ;

    logic              fetchGnt;
    logic              memGnt;
    logic              accept;
    logic              starve;
    logic              waitInc;
    logic [3:0]        waitCnt;

    fetch_starve_counter uStarve (
        .clk     (clk),
        .clr     (clr),
        .inc     (waitInc),
        .cntClr  (fetchGnt),
        .limit   (waitLimit),
        .starve  (starve),
        .waitCnt (waitCnt)
    );

    // fetchGnt is only ever high in stIdle, so it doubles as the counter clear.
    assign waitInc = (state == stIdle) && bus.fetchReq && !fetchGnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= stIdle;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        fetchGnt  = 1'b0;
        memGnt    = 1'b0;
        accept    = 1'b0;
        case (state)
            stIdle: begin
                memGnt   = bus.memReq && !starve;
                fetchGnt = bus.fetchReq && (!bus.memReq || starve);
                accept   = memGnt || fetchGnt;
                if (accept) begin
                    nextState = stIssue;
                end
            end
            stIssue: begin
                if (capWe || bus.ramReady) begin
                    nextState = stDone;
                end
            end
            stDone: begin
                nextState = stIdle;
            end
            default: begin
                nextState = stIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            capPort    <= PORT_FETCH;
            capWe      <= 1'b0;
            capAddr    <= '0;
            capWData   <= '0;
            ramWeQ     <= 1'b0;
            ramReQ     <= 1'b0;
            fetchDoneQ <= 1'b0;
            memDoneQ   <= 1'b0;
            fetchDataQ <= '0;
            memDataQ   <= '0;
        end else begin
            fetchDoneQ <= 1'b0;
            memDoneQ   <= 1'b0;
            case (state)
                stIdle: begin
                    if (accept) begin
                        capPort <= memGnt ? PORT_MEM : PORT_FETCH;
                        capWe   <= memGnt && bus.memWe;
                        capAddr <= memGnt ? bus.memAddr : bus.fetchAddr;
                        if (memGnt) begin
                            capWData <= bus.memWData;
                        end
                        ramWeQ  <= memGnt && bus.memWe;
                        ramReQ  <= !(memGnt && bus.memWe);
                    end
                end
                stIssue: begin
                    // Stores belong to the load/store port only; fetch never writes.
                    if (capWe) begin
                        ramWeQ   <= 1'b0;
                        memDoneQ <= 1'b1;
                    end else if (bus.ramReady) begin
                        ramReQ <= 1'b0;
                        if (capPort == PORT_MEM) begin
                            memDataQ <= bus.ramRData;
                            memDoneQ <= 1'b1;
                        end else begin
                            fetchDataQ <= bus.ramRData;
                            fetchDoneQ <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.fetchGnt    = fetchGnt;
    assign bus.memGnt      = memGnt;
    assign bus.fetchDone   = fetchDoneQ;
    assign bus.memDone     = memDoneQ;
    assign bus.fetchData   = fetchDataQ;
    assign bus.memData     = memDataQ;
    assign bus.ramWe       = ramWeQ;
    assign bus.ramRe       = ramReQ;
    assign bus.ramAddr     = capAddr;
    assign bus.ramReadAddr = capAddr;
    assign bus.ramWData    = capWData;
    assign bus.busy        = (state != stIdle);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed and randomized checks of data_ram_arbiter against a transaction-level
// reference model and a behavioural RAM.
module tb_data_ram_arbiter;

    localparam int MAXW = 3;

    logic clk = 1'b0;
    logic clr;

    data_ram_arbiter_if #(.width(16), .length(8)) bus ();

    data_ram_arbiter #(.width(16), .length(8), .maxWait(MAXW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #20 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    logic [15:0] ram    [256];
    logic [15:0] refMem [256];
    bit          ramLoaded = 1'b0;

    logic [15:0] mFetchData;
    logic [15:0] mMemData;

    function automatic logic [15:0] initVal(input int i);
        logic [15:0] v;
        v = 16'(i) * 16'h0101;
        return (i == 0) ? 16'h380F : (v ^ 16'h5A5A);
    endfunction

    // Behavioural single-ported RAM acting on the falling edge.
    always @(negedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= initVal(i);
            ramLoaded <= 1'b1;
        end else begin
            if (bus.ramWe) ram[bus.ramAddr] <= bus.ramWData;
            if (bus.ramRe) bus.ramRData <= ram[bus.ramReadAddr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated access from a single requester; readyLow = cycles ramReady stays low.
    task automatic runAccess(input bit isMem, input bit we, input logic [7:0] addr,
                             input logic [15:0] wd, input int readyLow, input string tag);
        logic [15:0] exp;
        bit          isStore;
        isStore = isMem && we;
        if (isMem) begin
            bus.memReq = 1'b1; bus.memWe = we; bus.memAddr = addr; bus.memWData = wd;
        end else begin
            bus.fetchReq = 1'b1; bus.fetchAddr = addr;
        end
        bus.ramReady = (readyLow == 0);
        #1;
        check({tag, " gnt"}, {bus.fetchGnt, bus.memGnt}, isMem ? 2'b01 : 2'b10);
        tick();
        bus.memReq = 1'b0; bus.fetchReq = 1'b0; bus.memWe = 1'b0;
        check({tag, " strobes"}, {bus.ramWe, bus.ramRe}, isStore ? 2'b10 : 2'b01);
        check({tag, " ramAddr"}, {bus.ramAddr, bus.ramReadAddr}, {addr, addr});
        check({tag, " busy"}, bus.busy, 1'b1);
        if (isStore) begin
            check({tag, " ramWData"}, bus.ramWData, wd);
            refMem[addr] = wd;
            exp = mMemData;
        end else begin
            exp = refMem[addr];
        end
        for (int i = 0; i < readyLow; i++) begin
            tick();
            check({tag, " wait ramRe"}, {bus.ramRe, bus.busy}, 2'b11);
            check({tag, " wait no done"}, {bus.fetchDone, bus.memDone}, 2'b00);
            if (i == readyLow - 1) bus.ramReady = 1'b1;
        end
        tick();
        check({tag, " done"}, {bus.fetchDone, bus.memDone}, isMem ? 2'b01 : 2'b10);
        check({tag, " data"}, isMem ? bus.memData : bus.fetchData, exp);
        check({tag, " strobes off"}, {bus.ramWe, bus.ramRe}, 2'b00);
        if (isMem) mMemData = exp; else mFetchData = exp;
        tick();
        check({tag, " done end"}, {bus.fetchDone, bus.memDone, bus.busy}, 3'b000);
    endtask

    initial begin
        bit          fPend, mPend, eF, eM, expFD, expMD, tMem, tWe;
        int          stage, mWait;
        logic [7:0]  tAddr;
        logic [1:0]  expG;

        for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
        mFetchData = '0;
        mMemData   = '0;

        clr = 1'b0;
        bus.fetchReq = 1'b0; bus.fetchAddr = '0;
        bus.memReq = 1'b0; bus.memWe = 1'b0; bus.memAddr = '0; bus.memWData = '0;
        bus.ramReady = 1'b1;
        repeat (3) tick();
        check("reset strobes", {bus.ramWe, bus.ramRe, bus.busy}, 3'b000);
        clr = 1'b1;
        tick();
        check("reset dones", {bus.fetchDone, bus.memDone, bus.fetchGnt, bus.memGnt}, 4'b0000);
        check("reset data", {bus.fetchData, bus.memData}, 32'h0);
        check("reset addr", bus.ramAddr, 8'h00);
        check("reset waitCnt", dut.waitCnt, 4'd0);

        runAccess(1'b1, 1'b1, 8'h28, 16'h1234, 0, "store28");
        runAccess(1'b1, 1'b0, 8'h28, 16'h0000, 0, "load28");
        check("load28 value", bus.memData, 16'h1234);
        runAccess(1'b0, 1'b0, 8'h00, 16'h0000, 0, "fetch0");
        check("fetch0 value", bus.fetchData, 16'h380F);
        runAccess(1'b1, 1'b0, 8'h05, 16'h0000, 2, "loadSlow");

        // Both requesters held: mem three times, then fetch, repeating.
        bus.fetchReq = 1'b1; bus.fetchAddr = 8'h01;
        bus.memReq = 1'b1; bus.memWe = 1'b0; bus.memAddr = 8'h02;
        bus.ramReady = 1'b1;
        #1;
        for (int k = 0; k < 24; k++) begin
            if (k % 3 == 0) expG = ((k / 3) % 4 == 3) ? 2'b10 : 2'b01;
            else            expG = 2'b00;
            check("starve gnt", {bus.fetchGnt, bus.memGnt}, expG);
            tick();
        end
        bus.fetchReq = 1'b0; bus.memReq = 1'b0;
        mFetchData = refMem[1];
        mMemData   = refMem[2];
        check("starve waitCnt", dut.waitCnt, 4'd0);

        // One refused fetch, then both idle: waitCnt must hold.
        bus.fetchReq = 1'b1; bus.memReq = 1'b1; bus.memAddr = 8'h03;
        #1;
        check("hold gnt", {bus.fetchGnt, bus.memGnt}, 2'b01);
        tick();
        bus.fetchReq = 1'b0; bus.memReq = 1'b0;
        check("hold waitCnt inc", dut.waitCnt, 4'd1);
        tick();
        tick();
        mMemData = refMem[3];
        for (int k = 0; k < 3; k++) begin
            check("idle outputs", {bus.fetchGnt, bus.memGnt, bus.busy, bus.ramWe, bus.ramRe}, 5'b00000);
            check("idle waitCnt", dut.waitCnt, 4'd1);
            tick();
        end

        // Reset in the middle of a store.
        bus.memReq = 1'b1; bus.memWe = 1'b1; bus.memAddr = 8'h40; bus.memWData = 16'hBEEF;
        #1;
        tick();
        bus.memReq = 1'b0; bus.memWe = 1'b0;
        check("clr pre strobe", bus.ramWe, 1'b1);
        clr = 1'b0;
        #1;
        check("clr outputs", {bus.ramWe, bus.ramRe, bus.busy, bus.memDone, bus.fetchDone}, 5'b00000);
        check("clr data", {bus.fetchData, bus.memData}, 32'h0);
        check("clr addr", bus.ramAddr, 8'h00);
        check("clr waitCnt", dut.waitCnt, 4'd0);
        tick();
        clr = 1'b1;
        mFetchData = '0;
        mMemData   = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("clr no done", {bus.memDone, bus.busy}, 2'b00);
        end
        runAccess(1'b1, 1'b0, 8'h40, 16'h0000, 0, "afterClr");

        // Randomized traffic against the transaction-level model.
        fPend = 0; mPend = 0; stage = 0; mWait = 0;
        expFD = 0; expMD = 0; tMem = 0; tWe = 0; tAddr = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!fPend && $urandom_range(0, 2) == 0) begin
                fPend = 1; bus.fetchAddr = 8'($urandom_range(0, 15));
            end
            if (!mPend && $urandom_range(0, 1) == 0) begin
                mPend = 1;
                bus.memWe    = 1'($urandom_range(0, 1));
                bus.memAddr  = 8'($urandom_range(0, 15));
                bus.memWData = 16'($urandom);
            end
            bus.fetchReq = fPend;
            bus.memReq   = mPend;
            bus.ramReady = ($urandom_range(0, 3) != 0);
            #1;
            eM = (stage == 0) && mPend && (mWait != MAXW);
            eF = (stage == 0) && fPend && (!mPend || mWait == MAXW);
            check("rnd gnt", {bus.fetchGnt, bus.memGnt}, {eF, eM});
            check("rnd done", {bus.fetchDone, bus.memDone}, {expFD, expMD});
            check("rnd data", {bus.fetchData, bus.memData}, {mFetchData, mMemData});
            check("rnd busy", bus.busy, (stage != 0));
            expFD = 0; expMD = 0;
            case (stage)
                0: begin
                    if (eM || eF) begin
                        tMem  = eM;
                        tWe   = eM && bus.memWe;
                        tAddr = eM ? bus.memAddr : bus.fetchAddr;
                        if (tWe) refMem[tAddr] = bus.memWData;
                        stage = 1;
                    end
                    if (eF) mWait = 0;
                    else if (fPend && mWait < MAXW) mWait++;
                    if (eM) mPend = 0;
                    if (eF) fPend = 0;
                end
                1: begin
                    if (tWe) begin
                        expMD = 1; stage = 2;
                    end else if (bus.ramReady) begin
                        if (tMem) begin mMemData = refMem[tAddr]; expMD = 1; end
                        else      begin mFetchData = refMem[tAddr]; expFD = 1; end
                        stage = 2;
                    end
                end
                default: stage = 0;
            endcase
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
